// File: rtl/gpc_accum.sv
// Pipelined generalized parallel counter: per-beat weighted popcount (stage 1)
// accumulated across a multi-beat packet (stage 2), result on valid/ready.
module gpc_accum #(
  parameter int N0    = 5,
  parameter int N1    = 1,
  parameter int ACC_W = 8,
  localparam int S_W  = $clog2(N0 + 2*N1 + 1),
  localparam int N1_W = (N1 > 0) ? N1 : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_last,
  input  logic [N0-1:0]    src0,
  input  logic [N1_W-1:0]  src1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] dst,
  output logic             out_ovf
);

  logic             s1_valid_q, s1_last_q;
  logic [S_W-1:0]   s1_sum_q, beat_sum_d;
  logic [ACC_W-1:0] acc_q, base_d, dst_q;
  logic             first_q, ovf_acc_q, out_valid_q, out_ovf_q;
  logic [ACC_W:0]   tot_d;
  logic             ovf_d, out_fire, s1_adv, accept;

  // S_W is sized for the all-ones beat, so this sum never truncates.
  always_comb begin
    beat_sum_d = '0;
    for (int i = 0; i < N0; i++) beat_sum_d = beat_sum_d + S_W'(src0[i]);
    for (int j = 0; j < N1; j++) beat_sum_d = beat_sum_d + S_W'({src1[j], 1'b0});
  end

  assign out_fire = out_valid_q & out_ready;
  assign s1_adv   = s1_valid_q & (~out_valid_q | out_fire);
  assign in_ready = ~s1_valid_q | s1_adv;
  assign accept   = in_valid & in_ready;

  // First beat of a packet starts from zero and clears the sticky overflow.
  assign base_d = first_q ? '0 : acc_q;
  assign tot_d  = {1'b0, base_d} + (ACC_W+1)'(s1_sum_q);
  assign ovf_d  = (~first_q & ovf_acc_q) | tot_d[ACC_W];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_last_q   <= 1'b0;
      s1_sum_q    <= '0;
      acc_q       <= '0;
      first_q     <= 1'b1;
      ovf_acc_q   <= 1'b0;
      out_valid_q <= 1'b0;
      dst_q       <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      if (accept) begin
        s1_sum_q   <= beat_sum_d;
        s1_last_q  <= in_last;
        s1_valid_q <= 1'b1;
      end else if (s1_adv) begin
        s1_valid_q <= 1'b0;
      end

      if (out_fire) out_valid_q <= 1'b0;

      // A last beat landing on a fire cycle overrides the clear above.
      if (s1_adv) begin
        if (s1_last_q) begin
          dst_q       <= tot_d[ACC_W-1:0];
          out_ovf_q   <= ovf_d;
          out_valid_q <= 1'b1;
          first_q     <= 1'b1;
        end else begin
          acc_q     <= tot_d[ACC_W-1:0];
          ovf_acc_q <= ovf_d;
          first_q   <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign dst       = dst_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_gpc_accum.sv
// Directed + randomized bench for gpc_accum across three parameter sets,
// scored against a packet-level arithmetic model.
module tb_gpc_accum;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance A: N0=5, N1=1, ACC_W=8
  logic a_valid, a_ready, a_last, a_src1, a_ovalid, a_ordy, a_ovf;
  logic [4:0] a_src0;
  logic [7:0] a_dst;
  // Instance B: N0=5, N1=1, ACC_W=5
  logic b_valid, b_ready, b_last, b_src1, b_ovalid, b_ordy, b_ovf;
  logic [4:0] b_src0, b_dst;
  // Instance C: N0=16, N1=4, ACC_W=6
  logic c_valid, c_ready, c_last, c_ovalid, c_ordy, c_ovf;
  logic [15:0] c_src0;
  logic [3:0]  c_src1;
  logic [5:0]  c_dst;

  gpc_accum #(.N0(5), .N1(1), .ACC_W(8)) u_a (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready), .in_last(a_last),
    .src0(a_src0), .src1(a_src1), .out_valid(a_ovalid), .out_ready(a_ordy),
    .dst(a_dst), .out_ovf(a_ovf));
  gpc_accum #(.N0(5), .N1(1), .ACC_W(5)) u_b (
    .clk(clk), .rst(rst), .in_valid(b_valid), .in_ready(b_ready), .in_last(b_last),
    .src0(b_src0), .src1(b_src1), .out_valid(b_ovalid), .out_ready(b_ordy),
    .dst(b_dst), .out_ovf(b_ovf));
  gpc_accum #(.N0(16), .N1(4), .ACC_W(6)) u_c (
    .clk(clk), .rst(rst), .in_valid(c_valid), .in_ready(c_ready), .in_last(c_last),
    .src0(c_src0), .src1(c_src1), .out_valid(c_ovalid), .out_ready(c_ordy),
    .dst(c_dst), .out_ovf(c_ovf));

  int passed = 0;
  int total  = 0;
  int pkt_sum = 0;     // running integer sum of the open packet on instance A
  int exp_q[$];        // expected results for A: ovf*256 + dst

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
  endtask

  // One clock on instance A with scoreboard: settle, observe handshakes, clock.
  task automatic step();
    int v;
    #2;
    if (rst) begin
      pkt_sum = 0;
      exp_q.delete();
    end else begin
      if (a_ovalid && a_ordy) begin
        if (exp_q.size() == 0) chk("sb_unexpected_out", 1, 0);
        else begin
          v = exp_q.pop_front();
          chk("sb_dst", a_dst, v % 256);
          chk("sb_ovf", a_ovf, v / 256);
        end
      end
      if (a_valid && a_ready) begin
        pkt_sum += $countones(a_src0) + 2 * $countones(a_src1);
        if (a_last) begin
          exp_q.push_back((pkt_sum > 255 ? 256 : 0) + (pkt_sum % 256));
          pkt_sum = 0;
        end
      end
    end
    @(posedge clk); #1;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    rst = 1'b1;
    a_valid = 0; a_last = 0; a_src0 = '0; a_src1 = 0; a_ordy = 1;
    b_valid = 0; b_last = 0; b_src0 = '0; b_src1 = 0; b_ordy = 1;
    c_valid = 0; c_last = 0; c_src0 = '0; c_src1 = '0; c_ordy = 1;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", a_ovalid, 0);
    chk("rst_dst", a_dst, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_in_ready", a_ready, 1);

    // Exhaustive single-beat packets, back to back.
    for (int k = 0; k < 64; k++) begin
      logic [5:0] code;
      code = 6'(k);
      a_valid = 1; a_last = 1; a_src0 = code[4:0]; a_src1 = code[5];
      step();
      chk("exh_first_latency", a_ovalid, (k >= 1) ? 1 : 0);
      if (k >= 1) begin
        code = 6'(k - 1);
        chk("exh_dst", a_dst, $countones(code[4:0]) + 2 * code[5]);
      end
    end
    a_valid = 0;
    step();
    chk("exh_3f_dst", a_dst, 7);
    chk("exh_3f_ovf", a_ovf, 0);
    step();
    chk("exh_drained", a_ovalid, 0);

    // Multi-beat packet: four beats of 7.
    for (int k = 0; k < 4; k++) begin
      a_valid = 1; a_src0 = 5'h1f; a_src1 = 1; a_last = (k == 3);
      step();
      chk("mb_no_early_out", a_ovalid, 0);
    end
    a_valid = 0;
    step();
    chk("mb_out_valid", a_ovalid, 1);
    chk("mb_dst", a_dst, 28);
    chk("mb_ovf", a_ovf, 0);
    step();
    chk("mb_single_pulse", a_ovalid, 0);

    // Backpressure: A (5) held while B (6) waits in stage 1.
    a_ordy = 0;
    a_valid = 1; a_last = 1; a_src0 = 5'h1f; a_src1 = 0;
    step();
    a_valid = 0;
    step();
    chk("bp_a_valid", a_ovalid, 1);
    chk("bp_a_dst", a_dst, 5);
    a_valid = 1; a_last = 1; a_src0 = 5'h0f; a_src1 = 1;
    step();
    a_valid = 0;
    chk("bp_in_ready_low", a_ready, 0);
    for (int k = 0; k < 10; k++) begin
      step();
      chk("bp_hold_dst", a_dst, 5);
      chk("bp_hold_valid", a_ovalid, 1);
      chk("bp_hold_in_ready", a_ready, 0);
    end
    a_ordy = 1;
    step();
    chk("bp_b_valid", a_ovalid, 1);
    chk("bp_b_dst", a_dst, 6);
    step();
    chk("bp_drained", a_ovalid, 0);

    // Reset mid-packet discards the partial sum.
    a_valid = 1; a_last = 0; a_src0 = 5'h1f; a_src1 = 1;
    step(); step();
    a_valid = 0;
    rst = 1;
    step();
    rst = 0;
    chk("mrst_out_valid", a_ovalid, 0);
    chk("mrst_dst", a_dst, 0);
    chk("mrst_in_ready", a_ready, 1);
    a_valid = 1; a_last = 1; a_src0 = 5'h07; a_src1 = 0;
    step();
    a_valid = 0;
    step();
    chk("mrst_dst_after", a_dst, 3);
    chk("mrst_ovf_after", a_ovf, 0);
    step();

    // Overflow on the ACC_W=5 instance.
    for (int k = 0; k < 5; k++) begin
      b_valid = 1; b_src0 = 5'h1f; b_src1 = 1; b_last = (k == 4);
      tick();
    end
    b_src0 = 5'h03; b_src1 = 0; b_last = 1;
    tick();
    b_valid = 0;
    chk("ovf_valid", b_ovalid, 1);
    chk("ovf_dst", b_dst, 3);
    chk("ovf_flag", b_ovf, 1);
    tick();
    chk("ovf_next_valid", b_ovalid, 1);
    chk("ovf_next_dst", b_dst, 2);
    chk("ovf_next_clear", b_ovf, 0);
    tick();
    chk("ovf_drained", b_ovalid, 0);

    // Parameter sweep on N0=16, N1=4, ACC_W=6: packets of 2 and 3 all-ones beats.
    for (int k = 0; k < 5; k++) begin
      c_valid = 1; c_src0 = 16'hffff; c_src1 = 4'hf; c_last = (k == 1 || k == 4);
      tick();
      if (k == 2) begin
        chk("sw_two_valid", c_ovalid, 1);
        chk("sw_two_dst", c_dst, 48);
        chk("sw_two_ovf", c_ovf, 0);
      end
    end
    c_valid = 0;
    tick();
    chk("sw_three_valid", c_ovalid, 1);
    chk("sw_three_dst", c_dst, 8);
    chk("sw_three_ovf", c_ovf, 1);

    // Randomized traffic on instance A against the packet-sum model.
    for (int k = 0; k < 400; k++) begin
      a_valid = ($urandom_range(0, 9) < 7);
      a_src0  = 5'($urandom);
      a_src1  = 1'($urandom);
      a_last  = ($urandom_range(0, 2) == 0);
      a_ordy  = ($urandom_range(0, 9) < 6);
      step();
    end
    a_valid = 0; a_last = 1; a_ordy = 1;
    repeat (6) step();
    chk("rand_all_results_seen", exp_q.size(), 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
